// File: rtl/sram_burst_scheduler.sv
// Shared SRAM port scheduler: picks write/read direction and queue, runs fixed-length bursts.
// Optional `define SRAM_SCHED_WRITE_PRIO_EN: strict write priority with a read forced after 4 writes.
module sram_burst_scheduler #(
    parameter int NUM_QUEUES        = 4,
    parameter int QUEUE_ID_WIDTH    = 2,
    parameter int BURST_LEN         = 8,
    parameter int CNT_WIDTH         = 8,
    parameter int TURNAROUND_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_QUEUES-1:0]     wr_req,
    input  logic [NUM_QUEUES-1:0]     rd_req,
    input  logic                      mem_ready,
    output logic                      grant_valid,
    output logic                      grant_is_write,
    output logic [QUEUE_ID_WIDTH-1:0] grant_queue_id,
    output logic                      beat,
    output logic                      beat_last,
    output logic [NUM_QUEUES-1:0]     burst_done,
    output logic                      busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2,
        S_TURN  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [3:0]                turn_q, turn_d;
    logic [QUEUE_ID_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [QUEUE_ID_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [QUEUE_ID_WIDTH-1:0] qid_q, qid_d;
    logic                      last_dir_q, last_dir_d;
    logic                      is_write_q, is_write_d;
    logic                      any_wr, any_rd, pick_write;
`ifdef SRAM_SCHED_WRITE_PRIO_EN
    logic [2:0]                wcnt_q, wcnt_d;
`endif

    // Round-robin search starting just after ptr; ptr itself is the last candidate.
    function automatic logic [QUEUE_ID_WIDTH-1:0] rr_pick(
        input logic [NUM_QUEUES-1:0]     req,
        input logic [QUEUE_ID_WIDTH-1:0] ptr
    );
        int                    idx;
        logic                  found;
        logic [NUM_QUEUES-1:0] sh;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
            sh = req >> idx;
            if (!found && sh[0]) begin
                rr_pick = QUEUE_ID_WIDTH'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            turn_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            qid_q      <= '0;
            last_dir_q <= 1'b0;
            is_write_q <= 1'b0;
`ifdef SRAM_SCHED_WRITE_PRIO_EN
            wcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            turn_q     <= turn_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            qid_q      <= qid_d;
            last_dir_q <= last_dir_d;
            is_write_q <= is_write_d;
`ifdef SRAM_SCHED_WRITE_PRIO_EN
            wcnt_q     <= wcnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        turn_d     = turn_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        qid_d      = qid_q;
        last_dir_d = last_dir_q;
        is_write_d = is_write_q;
        any_wr     = |wr_req;
        any_rd     = |rd_req;
`ifdef SRAM_SCHED_WRITE_PRIO_EN
        wcnt_d     = wcnt_q;
        pick_write = any_wr && !(any_rd && (wcnt_q >= 3'd4));
`else
        // Under contention, go opposite to the last direction (last_dir 1 = write).
        pick_write = any_wr && !(any_rd && last_dir_q);
`endif

        case (state_q)
            S_IDLE: begin
                if (any_wr || any_rd) begin
                    is_write_d = pick_write;
                    last_dir_d = pick_write;
                    turn_d     = '0;
                    if (pick_write) begin
                        qid_d    = rr_pick(wr_req, wr_ptr_q);
                        wr_ptr_d = qid_d;
                    end else begin
                        qid_d    = rr_pick(rd_req, rd_ptr_q);
                        rd_ptr_d = qid_d;
                    end
`ifdef SRAM_SCHED_WRITE_PRIO_EN
                    if (!pick_write)          wcnt_d = 3'd0;
                    else if (wcnt_q != 3'd7)  wcnt_d = wcnt_q + 3'd1;
`endif
                    state_d = (pick_write != last_dir_q) ? S_TURN : S_BURST;
                end
            end
            S_TURN: begin
                if (turn_q == 4'(TURNAROUND_CYCLES - 1)) begin
                    turn_d  = '0;
                    state_d = S_BURST;
                end else begin
                    turn_d = turn_q + 4'd1;
                end
            end
            S_BURST: begin
                if (mem_ready) begin
                    if (cnt_q == CNT_WIDTH'(BURST_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign grant_valid    = (state_q == S_BURST);
    assign grant_is_write = is_write_q;
    assign grant_queue_id = qid_q;
    assign beat           = grant_valid & mem_ready;
    assign beat_last      = beat && (cnt_q == CNT_WIDTH'(BURST_LEN - 1));
    assign burst_done     = (state_q == S_DONE) ? (NUM_QUEUES'(1) << qid_q) : '0;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_burst_scheduler.sv
// Bench for sram_burst_scheduler: burst-level reference model with randomized requests and mem_ready.
module tb_sram_burst_scheduler;
    localparam int N  = 4;
    localparam int QW = 2;
    localparam int BL = 8;
    localparam int CW = 8;
    localparam int T  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  wr_req = '0;
    logic [N-1:0]  rd_req = '0;
    logic          mem_ready = 1'b0;
    logic          grant_valid, grant_is_write, beat, beat_last, busy;
    logic [QW-1:0] grant_queue_id;
    logic [N-1:0]  burst_done;

    int n_tests = 0;
    int n_fail  = 0;

    int m_wr_ptr, m_rd_ptr;
    bit m_last_write;
`ifdef SRAM_SCHED_WRITE_PRIO_EN
    int m_wcnt;
`endif

    sram_burst_scheduler #(
        .NUM_QUEUES(N), .QUEUE_ID_WIDTH(QW), .BURST_LEN(BL),
        .CNT_WIDTH(CW), .TURNAROUND_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset), .wr_req(wr_req), .rd_req(rd_req),
        .mem_ready(mem_ready), .grant_valid(grant_valid),
        .grant_is_write(grant_is_write), .grant_queue_id(grant_queue_id),
        .beat(beat), .beat_last(beat_last), .burst_done(burst_done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_wr_ptr     = 0;
        m_rd_ptr     = 0;
        m_last_write = 1'b0;
`ifdef SRAM_SCHED_WRITE_PRIO_EN
        m_wcnt       = 0;
`endif
    endtask

    // Burst-level decision: direction, queue, and whether a turnaround precedes it.
    task automatic model_pick(input logic [N-1:0] wr, input logic [N-1:0] rd,
                              output bit is_w, output int q, output bit turn);
        int ptr;
        int c;
        if ((|wr) && (|rd)) begin
`ifdef SRAM_SCHED_WRITE_PRIO_EN
            is_w = (m_wcnt < 4);
`else
            is_w = !m_last_write;
`endif
        end else begin
            is_w = |wr;
        end
        ptr = is_w ? m_wr_ptr : m_rd_ptr;
        q = -1;
        for (int k = 1; k <= N; k++) begin
            c = (ptr + k) % N;
            if (q < 0 && (is_w ? wr[c] : rd[c])) q = c;
        end
        if (is_w) m_wr_ptr = q; else m_rd_ptr = q;
        turn = (is_w != m_last_write);
        m_last_write = is_w;
`ifdef SRAM_SCHED_WRITE_PRIO_EN
        if (!is_w) m_wcnt = 0;
        else if (m_wcnt < 7) m_wcnt = m_wcnt + 1;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wr_req = '0;
        rd_req = '0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // mode: 0 = mem_ready always high, 1 = random, 2 = pattern 1,0,0 repeating
    task automatic run_burst(input logic [N-1:0] wr, input logic [N-1:0] rd,
                             input int mode, input string name);
        bit ew, et, exp_last;
        int eq, n, beats, cyc;
        logic [N-1:0] exp_done;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_wait: busy=%b required 0", name, busy);
        end
        wr_req = wr;
        rd_req = rd;
        model_pick(wr, rd, ew, eq, et);
        @(negedge clk);
        wr_req = '0;
        rd_req = '0;
        n = 0;
        while (grant_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n !== (et ? T : 0)) begin
            n_fail++;
            $display("FAIL %s turn_cycles: got %0d required %0d", name, n, et ? T : 0);
        end
        beats = 0;
        cyc = 0;
        while (beats < BL && cyc < 200) begin
            case (mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = 1'($urandom_range(0, 1));
                default: mem_ready = (cyc % 3 == 0);
            endcase
            #1;
            exp_last = mem_ready && (beats == BL - 1);
            n_tests++;
            if ({grant_valid, grant_is_write, grant_queue_id, beat, beat_last} !==
                {1'b1, ew, QW'(eq), mem_ready, exp_last}) begin
                n_fail++;
                $display("FAIL %s burst_cycle%0d: vld/wr/q/beat/last=%b/%b/%0d/%b/%b required %b/%b/%0d/%b/%b",
                         name, cyc, grant_valid, grant_is_write, grant_queue_id, beat, beat_last,
                         1'b1, ew, eq, mem_ready, exp_last);
            end
            if (mem_ready) beats++;
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (beats !== BL) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d required %0d", name, beats, BL);
        end
        mem_ready = 1'b0;
        #1;
        exp_done = N'(1) << eq;
        n_tests++;
        if ({grant_valid, burst_done, busy} !== {1'b0, exp_done, 1'b1}) begin
            n_fail++;
            $display("FAIL %s done_cycle: vld=%b done=%b busy=%b required vld=0 done=%b busy=1",
                     name, grant_valid, burst_done, busy, exp_done);
        end
        @(negedge clk);
        n_tests++;
        if ({burst_done, busy} !== {N'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL %s after_done: done=%b busy=%b required done=0 busy=0",
                     name, burst_done, busy);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({grant_valid, grant_is_write, grant_queue_id, beat, beat_last, burst_done, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: vld=%b wr=%b q=%0d beat=%b last=%b done=%b busy=%b required all 0",
                     grant_valid, grant_is_write, grant_queue_id, beat, beat_last, burst_done, busy);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_idle();
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if ({grant_valid, busy, burst_done} !== '0) begin
                n_fail++;
                $display("FAIL idle_no_req: vld=%b busy=%b done=%b required 0", grant_valid, busy, burst_done);
            end
        end
    endtask

    task automatic test_single_writer();
        run_burst(4'b0100, 4'b0000, 0, "single_writer");
    endtask

    task automatic test_write_rr();
        for (int i = 0; i < 5; i++) run_burst(4'b1111, 4'b0000, 0, "write_rr");
    endtask

    task automatic test_alternation();
        for (int i = 0; i < 4; i++) run_burst(4'b0001, 4'b0010, 0, "alternation");
    endtask

    task automatic test_stall();
        run_burst(4'b0000, 4'b1000, 2, "stall_read");
        run_burst(4'b0010, 4'b0000, 2, "stall_write");
    endtask

    task automatic test_random();
        logic [N-1:0] w, r;
        for (int i = 0; i < 20; i++) begin
            w = N'($urandom_range(0, 15));
            r = N'($urandom_range(0, 15));
            if (w == '0 && r == '0) w = 4'b0001;
            run_burst(w, r, 1, "random");
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ew, et;
        int eq, n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        wr_req = 4'b0100;
        model_pick(4'b0100, 4'b0000, ew, eq, et);
        @(negedge clk);
        wr_req = '0;
        n = 0;
        while (grant_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({grant_valid, grant_is_write, grant_queue_id, beat, beat_last, burst_done, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_burst_async: vld=%b wr=%b q=%0d beat=%b last=%b done=%b busy=%b required all 0",
                     grant_valid, grant_is_write, grant_queue_id, beat, beat_last, burst_done, busy);
        end
        mem_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if ({burst_done, busy} !== '0) begin
                n_fail++;
                $display("FAIL reset_mid_burst_hold: done=%b busy=%b required 0", burst_done, busy);
            end
        end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_tests++;
        if ({burst_done, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_burst_release: done=%b busy=%b required 0", burst_done, busy);
        end
        run_burst(4'b1111, 4'b0000, 0, "after_reset_rr");
    endtask

`ifdef SRAM_SCHED_WRITE_PRIO_EN
    task automatic test_write_prio();
        do_reset();
        for (int i = 0; i < 10; i++) run_burst(4'b0001, 4'b0001, 0, "write_prio");
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_single_writer();
        test_write_rr();
        test_alternation();
        test_stall();
        test_random();
        test_reset_mid_burst();
`ifdef SRAM_SCHED_WRITE_PRIO_EN
        test_write_prio();
`endif
        do_reset();
        test_alternation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
